simd_alu_sched: RTL and testbench
=================================

# simd_alu_sched

Two-requester round-robin scheduler and sequencer for the 128-bit, 4-lane SIMD ALU. It accepts vector operations from two independent ready/valid requesters and drives the ALU's opcode and operand inputs. It also captures the ALU's registered result and returns it on a ready/valid response channel, tagged with the requester ID. It sits between the issue logic of the two SIMD pipes and the single shared ALU instance, and handles all sharing, sequencing and opcode screening.

## Interface
- DATA_W, 128: vector width; four 32-bit lanes, must match the ALU.
- CNT_W, 16: width of each per-requester completion counter.
- MAX_OP, 4'b1100: highest legal opcode. Opcodes above it are rejected without using the ALU.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  combinational; requester n is granted this cycle.
- req0_opcode / req1_opcode  in  4  operation code.
- req0_op1, req0_op2 / req1_op1, req1_op2  in  DATA_W  operands.
- alu_opcode  out  4  registered; drives the ALU opcode input.
- alu_operand1, alu_operand2  out  DATA_W  registered; drive the ALU operands.
- alu_result  in  DATA_W  registered ALU output, valid one edge after operands are sampled.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_err  out  1  1 = illegal opcode, operation not executed.
- rsp_result  out  DATA_W  result vector; 0 when rsp_err=1.
- busy  out  1  high whenever state != IDLE.
- done_cnt0 / done_cnt1  out  CNT_W  completed responses per requester; wrap modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP. One operation in flight at a time.
- IDLE: reqN_ready = 1 only for the granted requester; both are 0 in all other states.
- Grant rule: if only one valid is high, grant that requester. If both are high, grant the requester other than last_grant.
- last_grant resets to 1, so requester 0 wins the first contest. last_grant updates only on accept.
- Accept = IDLE && reqN_valid && reqN_ready. On accept:
  - latch the opcode into alu_opcode and the operands into alu_operand1/2;
  - latch N into rsp_id.
- Legal opcode (<= MAX_OP): next state is EXEC.
- Illegal opcode: next state is RESP with rsp_err=1 and rsp_result=0. In this case alu_opcode and alu_operand1/2 keep their previous values.
- EXEC: ALU inputs held stable; the ALU samples them at the end of this cycle. Next state is CAPT.
- CAPT: rsp_result <= alu_result, rsp_err <= 0. Next state is RESP.
- RESP: rsp_valid=1. rsp_id, rsp_err and rsp_result are held stable until rsp_valid && rsp_ready.
- On response handshake: increment done_cnt[rsp_id], then go to IDLE. Error responses also count.
- alu_* registers change only on a legal accept. The ALU sees stable inputs while unused.
- No combinational path from req*_valid to rsp_* or alu_*.

## Timing
- Reset values: state=IDLE, alu_opcode=0, alu_operand1/2=0, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_result=0, busy=0, done_cnt0/1=0, last_grant=1.
- Legal op accepted at edge N:
  - EXEC during cycle N..N+1;
  - ALU captures at edge N+1;
  - rsp_result loaded and rsp_valid=1 from edge N+2;
  - with rsp_ready tied high, handshake at edge N+3 and next accept at edge N+4 at the earliest;
  - best-case throughput is 1 operation per 4 cycles.
- Illegal op accepted at edge N: rsp_valid=1 from edge N; earliest handshake at N+1.
- rsp_ready low stalls in RESP indefinitely. Outputs are held, and requesters see ready=0 throughout.
- Reset asserted in any state, including mid-EXEC or CAPT: return immediately to reset values. The in-flight operation is dropped with no response, and counters are cleared.
- Counter at 2^CNT_W-1 plus one completion wraps to 0.

## Test plan
- Single ADD: req0 opcode 0000, op1 lanes {1,2,3,4}, op2 lanes {10,20,30,40}.
  -> rsp_valid 2 edges after accept, rsp_id=0, rsp_err=0, lanes {11,22,33,44}, done_cnt0=1.
- Contention: req0 and req1 both valid continuously with AND and XOR ops.
  -> grants alternate 0,1,0,1, starting with 0; rsp_id sequence matches.
- Backpressure: MUL lanes {3}x{5}, rsp_ready held low for 7 cycles.
  -> rsp_valid stays high, result stays 15 per lane, req*_ready stays 0, exactly one handshake occurs.
- Illegal opcode: req1 opcode 1111.
  -> rsp_valid at the accept edge, rsp_err=1, rsp_result=0, alu_* unchanged, done_cnt1 increments.
- Reset during EXEC of a DIV.
  -> all outputs return to reset values, no response appears, and the next request is granted to requester 0.
- Counter wrap with CNT_W=2: five completions on requester 0.
  -> done_cnt0 reads 1,2,3,0,1.

Source files
------------

// File: rtl/simd_alu_sched.sv
// Round-robin scheduler and sequencer that shares one 4-lane SIMD ALU between two requesters.
// Screens opcodes, issues operands, captures the ALU result and returns it as a tagged response.
module simd_alu_sched #(
  parameter int         DATA_W = 128,
  parameter int         CNT_W  = 16,
  parameter logic [3:0] MAX_OP = 4'b1100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_result,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t              state_reg, state_next;
  logic                last_grant_reg;
  logic [3:0]          alu_opcode_reg;
  logic [DATA_W-1:0]   alu_operand1_reg;
  logic [DATA_W-1:0]   alu_operand2_reg;
  logic                rsp_id_reg;
  logic                rsp_err_reg;
  logic [DATA_W-1:0]   rsp_result_reg;

  logic                gnt_id;
  logic                accept;
  logic                legal;
  logic                rsp_hs;
  logic [3:0]          sel_opcode;
  logic [DATA_W-1:0]   sel_op1;
  logic [DATA_W-1:0]   sel_op2;

  // A lone requester always wins; on contention the one not served last time wins.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = ~last_grant_reg;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  assign accept     = (state_reg == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign sel_opcode = gnt_id ? req1_opcode : req0_opcode;
  assign sel_op1    = gnt_id ? req1_op1 : req0_op1;
  assign sel_op2    = gnt_id ? req1_op2 : req0_op2;
  assign legal      = (sel_opcode <= MAX_OP);
  assign rsp_hs     = (state_reg == RESP) && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = legal ? EXEC : RESP;
      EXEC:    state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Illegal opcodes bypass the ALU entirely so its inputs stay untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg   <= 1'b1;
      alu_opcode_reg   <= '0;
      alu_operand1_reg <= '0;
      alu_operand2_reg <= '0;
      rsp_id_reg       <= 1'b0;
      rsp_err_reg      <= 1'b0;
      rsp_result_reg   <= '0;
    end else begin
      if (accept) begin
        last_grant_reg <= gnt_id;
        rsp_id_reg     <= gnt_id;
        if (legal) begin
          alu_opcode_reg   <= sel_opcode;
          alu_operand1_reg <= sel_op1;
          alu_operand2_reg <= sel_op2;
        end else begin
          rsp_err_reg    <= 1'b1;
          rsp_result_reg <= '0;
        end
      end
      if (state_reg == CAPT) begin
        rsp_result_reg <= alu_result;
        rsp_err_reg    <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                               cnt_reg <= '0;
        else if (rsp_hs && rsp_id_reg == 1'(gi)) cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  endgenerate

  assign done_cnt0    = g_cnt[0].cnt_reg;
  assign done_cnt1    = g_cnt[1].cnt_reg;
  assign alu_opcode   = alu_opcode_reg;
  assign alu_operand1 = alu_operand1_reg;
  assign alu_operand2 = alu_operand2_reg;
  assign rsp_valid    = (state_reg == RESP);
  assign rsp_id       = rsp_id_reg;
  assign rsp_err      = rsp_err_reg;
  assign rsp_result   = rsp_result_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_simd_alu_sched.sv
// Scoreboard bench for simd_alu_sched: randomized requests, a behavioural ALU and a
// transaction-level model of arbitration, screening and response ordering.
module tb_simd_alu_sched;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 2;
  localparam logic [3:0] MAX_OP = 4'b1100;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]        req0_opcode, req1_opcode;
  logic [DATA_W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operand1, alu_operand2, alu_result;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DATA_W-1:0] rsp_result;
  logic              busy;
  logic [CNT_W-1:0]  done_cnt0, done_cnt1;

  simd_alu_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_OP(MAX_OP)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_result(rsp_result), .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              id;
    logic              err;
    logic [DATA_W-1:0] res;
    int                acc;
  } exp_t;

  exp_t              sbq[$];
  bit                front_seen;
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  bit                p_val [2];
  logic [3:0]        p_opc [2];
  logic [DATA_W-1:0] p_a [2];
  logic [DATA_W-1:0] p_b [2];
  bit                m_inflight;
  logic              m_last;
  logic [CNT_W-1:0]  m_cnt [2];
  logic [3:0]        m_aluop;
  logic [DATA_W-1:0] m_alu1, m_alu2;
  logic [DATA_W-1:0] last_res;

  // Behavioural 4-lane ALU with its own opcode map.
  function automatic logic [DATA_W-1:0] alu_fn(input logic [3:0] op,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] r;
    logic [31:0] a, b, q;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      a = x[l*32 +: 32];
      b = y[l*32 +: 32];
      case (op)
        4'd0:    q = a + b;
        4'd1:    q = a - b;
        4'd2:    q = a * b;
        4'd3:    q = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        4'd4:    q = a & b;
        4'd5:    q = a | b;
        4'd6:    q = a ^ b;
        4'd7:    q = (a < b) ? a : b;
        4'd8:    q = (a > b) ? a : b;
        4'd9:    q = a << b[4:0];
        4'd10:   q = a >> b[4:0];
        4'd11:   q = ~a;
        4'd12:   q = a + b + 32'd1;
        default: q = 32'd0;
      endcase
      r[l*32 +: 32] = q;
    end
    return r;
  endfunction

  always @(posedge clk) alu_result <= alu_fn(alu_opcode, alu_operand1, alu_operand2);
  always @(posedge clk) cyc++;

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int k, input logic [3:0] opc, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b);
    p_val[k] = 1'b1;
    p_opc[k] = opc;
    p_a[k]   = a;
    p_b[k]   = b;
  endtask

  // One clock of stimulus: present pending requests, predict the grant, push the expectation.
  task automatic step();
    bit   g;
    logic gid;
    exp_t e;
    req0_valid = p_val[0]; req0_opcode = p_opc[0]; req0_op1 = p_a[0]; req0_op2 = p_b[0];
    req1_valid = p_val[1]; req1_opcode = p_opc[1]; req1_op1 = p_a[1]; req1_op2 = p_b[1];
    @(negedge clk);
    g   = 1'b0;
    gid = 1'b0;
    if (!m_inflight && (p_val[0] || p_val[1])) begin
      g   = 1'b1;
      gid = (p_val[0] && p_val[1]) ? ~m_last : p_val[1];
    end
    chk("req0_ready", req0_ready, g && !gid);
    chk("req1_ready", req1_ready, g && gid);
    if (g) begin
      e.id  = gid;
      e.err = (p_opc[gid] > MAX_OP);
      e.res = e.err ? '0 : alu_fn(p_opc[gid], p_a[gid], p_b[gid]);
      e.acc = cyc + 1;
      sbq.push_back(e);
      m_last     = gid;
      m_inflight = 1'b1;
      if (!e.err) begin
        m_aluop = p_opc[gid];
        m_alu1  = p_a[gid];
        m_alu2  = p_b[gid];
      end
    end
    @(posedge clk);
    #1;
    if (g) p_val[gid] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((p_val[0] || p_val[1] || m_inflight || sbq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain: got %0d outstanding after %0d cycles, expected 0", sbq.size(), n);
    end
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    p_val[0] = 1'b0; p_val[1] = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    sbq.delete();
    front_seen = 1'b0;
    m_inflight = 1'b0;
    m_last     = 1'b1;
    m_cnt[0]   = '0; m_cnt[1] = '0;
    m_aluop    = '0; m_alu1 = '0; m_alu2 = '0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_operand1", alu_operand1, 0);
    chk("rst_alu_operand2", alu_operand2, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_cnt0", done_cnt0, 0);
    chk("rst_done_cnt1", done_cnt1, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!reset) begin
      chk("done_cnt0", done_cnt0, m_cnt[0]);
      chk("done_cnt1", done_cnt1, m_cnt[1]);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d, expected no response", rsp_id);
        end else begin
          e = sbq[0];
          if (!front_seen) begin
            chk("rsp_latency", cyc - e.acc, e.err ? 0 : 2);
            front_seen = 1'b1;
          end
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_result", rsp_result, e.res);
          chk("busy_in_resp", busy, 1);
          chk("req0_ready_in_resp", req0_ready, 0);
          chk("req1_ready_in_resp", req1_ready, 0);
          if (rsp_ready) begin
            chk("alu_opcode", alu_opcode, m_aluop);
            chk("alu_operand1", alu_operand1, m_alu1);
            chk("alu_operand2", alu_operand2, m_alu2);
            void'(sbq.pop_front());
            front_seen  = 1'b0;
            m_cnt[e.id] = m_cnt[e.id] + CNT_W'(1);
            m_inflight  = 1'b0;
            last_res    = rsp_result;
            $display("rsp id=%0d err=%0d result=%h done_cnt=%0d", e.id, e.err, rsp_result, m_cnt[e.id]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_exp [5];
    wrap_exp = '{1, 2, 3, 0, 1};
    reset = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opcode = '0; req1_opcode = '0;
    req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
    p_opc[0] = '0; p_opc[1] = '0;
    p_a[0] = '0; p_a[1] = '0; p_b[0] = '0; p_b[1] = '0;
    last_res = '0;
    do_reset(2);

    // single ADD
    rsp_ready = 1'b1;
    load(0, 4'd0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10});
    drain(50);
    chk("add_result", last_res, {32'd44, 32'd33, 32'd22, 32'd11});
    chk("add_cnt0", done_cnt0, 1);

    // contention: AND on req0, XOR on req1, both kept valid
    for (int i = 0; i < 24; i++) begin
      if (!p_val[0]) load(0, 4'd4, rnd128(), rnd128());
      if (!p_val[1]) load(1, 4'd6, rnd128(), rnd128());
      step();
    end
    drain(50);

    // backpressure on a MUL with req1 waiting
    load(0, 4'd2, {4{32'd3}}, {4{32'd5}});
    step();
    load(1, 4'd0, rnd128(), rnd128());
    rsp_ready = 1'b0;
    repeat (9) step();
    rsp_ready = 1'b1;
    step();
    chk("mul_result", last_res, {4{32'd15}});
    drain(50);

    // illegal opcode on req1
    load(1, 4'hF, rnd128(), rnd128());
    drain(50);
    chk("illegal_result", last_res, 0);

    // reset while a DIV is executing
    load(0, 4'd3, rnd128(), rnd128());
    step();
    do_reset(2);

    // counter wrap; first request contends and must go to requester 0
    for (int i = 0; i < 5; i++) begin
      load(0, 4'd0, rnd128(), rnd128());
      if (i == 0) load(1, 4'd1, rnd128(), rnd128());
      drain(50);
      chk("wrap_cnt0", done_cnt0, wrap_exp[i]);
    end

    // random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++)
        if (!p_val[k] && $urandom_range(0, 2) != 0)
          load(k, 4'($urandom_range(0, 15)), rnd128(), rnd128());
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
